// File: rtl/mips32_ctl_pkg.sv
// Shared types for the mips32 run controller: host opcodes, response codes
// and controller FSM states.
package mips32_ctl_pkg;

  typedef enum logic [1:0] {
    OP_WR_IMEM = 2'd0,
    OP_WR_DMEM = 2'd1,
    OP_RUN     = 2'd2,
    OP_RD_DMEM = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_HALTED  = 2'd1,
    RSP_TIMEOUT = 2'd2
  } rsp_status_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RUN     = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_RESP    = 3'd5
  } ctl_state_e;

endpackage

// File: rtl/run_timer.sv
// Clear/enable cycle counter with a budget compare; expire flags the last
// enabled cycle of a budget so the owner can act on the same edge.
module run_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] budget_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  // Budget bounds the count, so cnt+1 never wraps for a nonzero budget.
  assign expire_o = en_i && ((cnt_q + CNT_W'(1)) == budget_i);

endmodule

// File: rtl/mips32_run_ctl.sv
// Host command controller for the mips32 core: preload imem/dmem, run the
// core until halt or budget expiry, and read data memory back.
//
// state      | meaning
// IDLE       | cmd_ready high, waiting for a host command
// WRITE      | one-cycle imem/dmem write strobe
// RUN        | core released, cycle counter running
// RD_REQ     | dmem address presented
// RD_WAIT    | registered dmem read data captured
// RESP       | response held until rsp_ready
module mips32_run_ctl
  import mips32_ctl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 32
) (
  input  logic              clk_x,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_status,
  output logic [DATA_W-1:0] rsp_data,
  output logic              imem_we,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              core_rst,
  input  logic              core_halt,
  output logic [CNT_W-1:0]  cycle_cnt
);

  ctl_state_e        state_q, state_d;
  rsp_status_e       rsp_status_q, rsp_status_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              imem_we_q, imem_we_d;
  logic              dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  budget_q, budget_d;
  logic              core_rst_q, core_rst_d;

  logic              tmr_clr, tmr_en, tmr_expire;
  logic [CNT_W-1:0]  tmr_cnt;

  run_timer #(.CNT_W(CNT_W)) u_run_timer (
    .clk_i    (clk_x),
    .rst_ni   (rst),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .budget_i (budget_q),
    .cnt_o    (tmr_cnt),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d      = state_q;
    rsp_status_d = rsp_status_q;
    rsp_data_d   = rsp_data_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    budget_d     = budget_q;
    imem_we_d    = 1'b0;
    dmem_we_d    = 1'b0;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          mem_addr_d   = cmd_addr;
          mem_wdata_d  = cmd_data;
          budget_d     = cmd_data[CNT_W-1:0];
          rsp_status_d = RSP_OK;
          rsp_data_d   = '0;
          unique case (cmd_op_e'(cmd_op))
            OP_WR_IMEM: begin
              imem_we_d = 1'b1;
              state_d   = ST_WRITE;
            end
            OP_WR_DMEM: begin
              dmem_we_d = 1'b1;
              state_d   = ST_WRITE;
            end
            OP_RUN: begin
              tmr_clr = 1'b1;
              // A zero budget never releases the core.
              if (cmd_data[CNT_W-1:0] == '0) begin
                rsp_status_d = RSP_TIMEOUT;
                state_d      = ST_RESP;
              end else begin
                state_d = ST_RUN;
              end
            end
            OP_RD_DMEM: state_d = ST_RD_REQ;
            default:    state_d = ST_IDLE;
          endcase
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RUN: begin
        tmr_en = 1'b1;
        if (core_halt) begin
          rsp_status_d = RSP_HALTED;
          rsp_data_d   = DATA_W'(tmr_cnt);
          state_d      = ST_RESP;
        end else if (tmr_expire) begin
          rsp_status_d = RSP_TIMEOUT;
          rsp_data_d   = DATA_W'(budget_q);
          state_d      = ST_RESP;
        end
      end
      ST_RD_REQ: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        rsp_data_d = dmem_rdata;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    rsp_valid_d = (state_d == ST_RESP);
    core_rst_d  = (state_d != ST_RUN);
  end

  always_ff @(posedge clk_x) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      rsp_status_q <= RSP_OK;
      rsp_data_q   <= '0;
      rsp_valid_q  <= 1'b0;
      imem_we_q    <= 1'b0;
      dmem_we_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      budget_q     <= '0;
      core_rst_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      rsp_status_q <= rsp_status_d;
      rsp_data_q   <= rsp_data_d;
      rsp_valid_q  <= rsp_valid_d;
      imem_we_q    <= imem_we_d;
      dmem_we_q    <= dmem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      budget_q     <= budget_d;
      core_rst_q   <= core_rst_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = rsp_status_q;
  assign rsp_data   = rsp_data_q;
  assign imem_we    = imem_we_q;
  assign dmem_we    = dmem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_rst   = core_rst_q;
  assign cycle_cnt  = tmr_cnt;

endmodule

// File: tb/tb_mips32_run_ctl.sv
// Randomized bench for mips32_run_ctl with behavioural memories, a core stub
// that halts a chosen number of cycles after release, and a response model.
module tb_mips32_run_ctl;

  logic        clk_x = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [9:0]  cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_data;
  logic        imem_we, dmem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] dmem_rdata;
  logic        core_rst;
  logic        core_halt;
  logic [31:0] cycle_cnt;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk_x = ~clk_x;

  mips32_run_ctl dut (
    .clk_x      (clk_x),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_status (rsp_status),
    .rsp_data   (rsp_data),
    .imem_we    (imem_we),
    .dmem_we    (dmem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .dmem_rdata (dmem_rdata),
    .core_rst   (core_rst),
    .core_halt  (core_halt),
    .cycle_cnt  (cycle_cnt)
  );

  // Environment: memories with a registered dmem read, and a core stub.
  logic [31:0] imem [0:1023];
  logic [31:0] dmem [0:1023];
  logic [31:0] dmem_rd_q;
  logic [31:0] core_age;
  int          halt_at = 100000;
  logic        halt_noise = 1'b0;

  always_ff @(posedge clk_x) begin
    if (imem_we) imem[mem_addr] <= mem_wdata;
    if (dmem_we) dmem[mem_addr] <= mem_wdata;
    dmem_rd_q <= dmem[mem_addr];
    core_age  <= core_rst ? 32'd0 : core_age + 32'd1;
  end
  assign dmem_rdata = dmem_rd_q;
  assign core_halt  = (!core_rst && (int'(core_age) >= halt_at)) || halt_noise;

  // Expected memory contents as seen by the host.
  logic [31:0] imem_exp [0:1023];
  logic [31:0] dmem_exp [0:1023];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Issue one command, model its outcome, and check the whole transaction.
  task automatic txn(input logic [1:0] op, input logic [9:0] addr, input logic [31:0] data,
                     input int hold);
    logic [1:0]  e_st;
    logic [31:0] e_data, st0, d0;
    int e_lat, e_lo, e_wi, e_wd, bud;
    int lat, lo, wi, wd;
    e_st = 2'd0; e_data = '0; e_lo = 0; e_wi = 0; e_wd = 0; e_lat = 0;
    case (op)
      2'd0: begin e_lat = 2; e_wi = 1; imem_exp[addr] = data; end
      2'd1: begin e_lat = 2; e_wd = 1; dmem_exp[addr] = data; end
      2'd2: begin
        bud = int'(data);
        if (bud == 0) begin
          e_st = 2'd2; e_lat = 1;
        end else if (halt_at < bud) begin
          e_st = 2'd1; e_data = 32'(halt_at); e_lo = halt_at + 1; e_lat = halt_at + 2;
        end else begin
          e_st = 2'd2; e_data = 32'(bud); e_lo = bud; e_lat = bud + 1;
        end
      end
      default: begin e_lat = 3; e_data = dmem_exp[addr]; end
    endcase

    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    @(negedge clk_x);
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_addr = 10'($urandom); cmd_data = $urandom;
    lat = 1; lo = 0; wi = 0; wd = 0;
    while (!rsp_valid && lat < 500) begin
      if (!core_rst) begin
        chk("cycle_cnt_live", cycle_cnt, 32'(lo));
        lo++;
      end
      if (imem_we || dmem_we) begin
        wi += int'(imem_we); wd += int'(dmem_we);
        chk("we_addr", 32'(mem_addr), 32'(addr));
        chk("we_wdata", mem_wdata, data);
      end
      chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      @(negedge clk_x);
      lat++;
    end
    chk("latency", 32'(lat), 32'(e_lat));
    chk("core_rst_low_cycles", 32'(lo), 32'(e_lo));
    chk("imem_we_pulses", 32'(wi), 32'(e_wi));
    chk("dmem_we_pulses", 32'(wd), 32'(e_wd));
    chk("rsp_status", 32'(rsp_status), 32'(e_st));
    chk("rsp_data", rsp_data, e_data);
    chk("core_rst_in_resp", 32'(core_rst), 32'd1);
    st0 = 32'(rsp_status); d0 = rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_x);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_status", 32'(rsp_status), st0);
      chk("hold_data", rsp_data, d0);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk_x);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    if (op == 2'd0) chk("imem_content", imem[addr], imem_exp[addr]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [9:0]  a;
    logic [31:0] d;

    repeat (2) @(negedge clk_x);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_status", 32'(rsp_status), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_we", {30'd0, imem_we, dmem_we}, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_cycle_cnt", cycle_cnt, 32'd0);
    rst = 1'b1;
    @(negedge clk_x);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    txn(2'd0, 10'd1, 32'hC020_0001, 0);
    txn(2'd0, 10'd2, 32'hC040_0002, 0);
    for (int i = 0; i < 16; i++) txn(2'd1, 10'(i), $urandom, 0);

    halt_at = 100000;
    txn(2'd2, '0, 32'd5, 0);              // pure timeout
    txn(2'd2, '0, 32'd0, 0);              // zero budget
    halt_at = 3;  txn(2'd2, '0, 32'd4, 0); // halt and expiry together
    halt_at = 4;  txn(2'd2, '0, 32'd4, 0); // halt one cycle too late
    halt_at = 0;  txn(2'd2, '0, 32'd1, 0);
    halt_at = 2;  txn(2'd2, '0, 32'd9, 0);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 10'($urandom_range(0, 15));
      if (op == 2'd2) begin
        halt_noise = 1'b0;
        halt_at = ($urandom_range(0, 3) == 0) ? 100000 : int'($urandom_range(0, 15));
        d = 32'($urandom_range(0, 12));
      end else begin
        halt_noise = 1'($urandom_range(0, 1));
        d = $urandom;
      end
      txn(op, a, d, int'($urandom_range(0, 2)));
    end
    halt_noise = 1'b0;

    txn(2'd3, 10'd5, '0, 10);             // long backpressure on a read

    txn(2'd1, 10'd7, 32'hDEAD_BEEF, 0);
    halt_at = 100000;
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_data = 32'd50;
    @(negedge clk_x);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk_x);
    chk("midrun_core_rst", 32'(core_rst), 32'd0);
    chk("midrun_cycle_cnt", cycle_cnt, 32'd2);
    rst = 1'b0;
    @(negedge clk_x);
    chk("midrst_core_rst", 32'(core_rst), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_cycle_cnt", cycle_cnt, 32'd0);
    rst = 1'b1;
    @(negedge clk_x);
    txn(2'd3, 10'd7, '0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mips32_run_ctl.md
# mips32_run_ctl

Synthesizable load/run/readback controller for the mips32 pipeline. It turns bench-style memory preloading and fixed-time runs into a host command interface. Commands write instruction or data memory, run the core until halt or a cycle budget expires, and read data memory back. It sits between a host port (UART bridge or test harness) and the core's reset, halt flag and memory write/read ports.

## Interface
Parameters:
- DATA_W, 32, memory word and host data width
- ADDR_W, 10, word address width for both memories (depth 2**ADDR_W)
- CNT_W, 32, cycle counter and budget width (CNT_W <= DATA_W)

Ports:
- clk_x  in  1  single clock
- rst  in  1  synchronous, active-low reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  controller accepts command
- cmd_op  in  2  command opcode: 0 WR_IMEM, 1 WR_DMEM, 2 RUN, 3 RD_DMEM
- cmd_addr  in  ADDR_W  word address (WR/RD)
- cmd_data  in  DATA_W  write data (WR) or cycle budget in low CNT_W bits (RUN)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host takes response
- rsp_status  out  2  0 OK, 1 HALTED, 2 TIMEOUT
- rsp_data  out  DATA_W  read data (RD), cycle count zero-extended (RUN), 0 (WR)
- imem_we, dmem_we  out  1  one-cycle write strobes
- mem_addr  out  ADDR_W  shared address to both memories
- mem_wdata  out  DATA_W  shared write data
- dmem_rdata  in  DATA_W  data memory read data, 1-cycle registered latency
- core_rst  out  1  core reset, active-high (core runs when 0)
- core_halt  in  1  core halted flag (HLT retired)
- cycle_cnt  out  CNT_W  live run cycle counter

## Operation
- FSM states: IDLE, WRITE, RUN, RD_REQ, RD_WAIT, RESP.
- IDLE: cmd_ready=1. Handshake happens on cmd_valid&cmd_ready. The controller latches op/addr/data.
  - WR_* goes to WRITE.
  - RUN goes to RUN, or straight to RESP/TIMEOUT with count 0 if the budget is 0. With budget 0 the core is never released.
  - RD_DMEM goes to RD_REQ.
- WRITE: the matching *_we is high for exactly one cycle, with mem_addr/mem_wdata valid. Next state is RESP, status OK.
- RUN: core_rst=0 and cycle_cnt increments every RUN cycle, starting from 0 at entry.
  - core_halt=1 goes to RESP with status HALTED and data = cycle_cnt at that cycle.
  - Otherwise, cycle_cnt+1 == budget goes to RESP with status TIMEOUT and data = budget.
  - If halt and budget expiry occur in the same cycle, HALTED wins.
- RD_REQ drives mem_addr and goes to RD_WAIT. RD_WAIT captures dmem_rdata into rsp_data and goes to RESP, status OK.
- RESP: rsp_valid=1. rsp_status and rsp_data stay stable until rsp_ready. The handshake returns the FSM to IDLE.
- core_halt is ignored outside RUN. cmd_valid is ignored outside IDLE.
- core_rst=1 in every state except RUN. The core therefore restarts from PC 0 on every RUN, and memory contents persist across runs.
- cycle_cnt holds its final value until the next RUN entry.
- Width: cycle_cnt does not wrap, because the budget bounds it. The maximum budget is 2**CNT_W-1.

## Timing
- Reset (rst=0 at an edge) outputs:
  - FSM IDLE, cmd_ready=1 on the cycle after release
  - rsp_valid=0, rsp_status=0, rsp_data=0
  - imem_we=dmem_we=0, mem_addr=0, mem_wdata=0
  - core_rst=1, cycle_cnt=0
- Reset mid-RUN reasserts core_rst at the same edge and drops any pending response.
- Latency from command accept to rsp_valid:
  - WR: 2 cycles
  - RD: 3 cycles
  - RUN: budget+1 cycles, or halt cycle+1
- All outputs are registered. No combinational path from cmd_* or rsp_ready to outputs, except that cmd_ready equals (state==IDLE).
- Back-to-back: the earliest next accept is the cycle after the rsp handshake.

## Structure
- mips32_ctl_pkg holds:
  - the cmd_op enum (WR_IMEM, WR_DMEM, RUN, RD_DMEM)
  - the rsp_status enum (OK, HALTED, TIMEOUT)
  - the FSM state enum
- One sub-module, run_timer: a clear/enable counter with a budget compare that outputs expire. It is reused by later watchdog work.

## Test plan
- WR_IMEM addr 1 data 0xC0200001, then addr 2 data 0xC0400002 → imem_we pulses once per command with the matching addr/data. Each command returns OK with data 0.
- Load the 7-instruction program (loads, add, ALU RAW, store to d3, branch, HLT at addr 12) plus dmem[1..2], then RUN budget 100 → HALTED with count < 100. RD_DMEM addr 3 returns 2*(d1+d2) truncated to 32 bits.
- RUN budget 5 with imem all NOP → core_rst low for exactly 5 cycles, then TIMEOUT with data 5. core_rst=1 the cycle after.
- RUN budget 0 → TIMEOUT with data 0, and core_rst never deasserts.
- Hold rsp_ready=0 for 10 cycles after a RD → rsp_valid/data stay stable and cmd_ready stays 0. The first rsp_ready completes the response.
- Assert rst=0 for 1 cycle at RUN cycle 3 → the next edge gives core_rst=1, rsp_valid=0, IDLE, cycle_cnt=0. A following RD_DMEM still returns previously written data.
